fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Shares one combinational single-precision multiplier among NUM_REQ requesters, e.g. parallel Newton-Raphson iteration units that each need f(x) and f'(x) products.
- Round-robin grant with a valid/ready handshake on every requester port.
- Two register stages: operand register, then response register. The response carries a requester ID and the multiplier's status flags.
- The multiplier sits outside this block. This block drives its operands and captures its result and flags.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  32*NUM_REQ  operand A; requester i in bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same packing.
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when req_valid[i] & req_ready[i].
- mul_a  out  32  operand A to the external multiplier (operand register).
- mul_b  out  32  operand B to the external multiplier.
- mul_result  in  32  multiplier result, combinational from mul_a/mul_b.
- mul_exception  in  1  multiplier exception flag.
- mul_overflow  in  1  multiplier overflow flag.
- mul_underflow  in  1  multiplier underflow flag.
- rsp_valid  out  1  response register holds a valid result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  requester that issued the operation.
- rsp_result  out  32  product.
- rsp_flags  out  3  {exception, overflow, underflow}.
- op_count  out  16  number of accepted operations; wraps.

Behaviour:
- Reset (rst_n low, asynchronous) clears all registers:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0.
  - op_valid=0, mul_a=0, mul_b=0.
  - RR pointer=0, op_count=0.
- Reset mid-operation discards in-flight operand and response contents; nothing is replayed.
- Pipeline advance:
  - rsp_adv = !rsp_valid | rsp_ready.
  - op_adv = !op_valid | rsp_adv.
- Grant:
  - When op_adv=1, req_ready is one-hot on the first asserted req_valid searching upward from the pointer, wrapping NUM_REQ-1 to 0.
  - When op_adv=0, or no request is present, req_ready=0.
  - req_ready is combinational from req_valid, the pointer and op_adv. Requesters must not make req_valid depend on req_ready.
- On accept of requester g:
  - Operand register loads req_a[g], req_b[g], id=g; op_valid<=1.
  - Pointer <= (g+1) mod NUM_REQ.
  - op_count increments, wrapping 0xFFFF to 0x0000.
  - Without an accept, the pointer holds.
- On op_adv with no accept: op_valid<=0. mul_a/mul_b hold their last values.
- Response register:
  - On rsp_adv with op_valid=1: loads mul_result, the three flags and op id; rsp_valid<=1.
  - On rsp_adv with op_valid=0: rsp_valid<=0; data fields hold.
- Backpressure:
  - While rsp_valid & !rsp_ready, the response register and operand register both hold, and req_ready=0.
  - mul_a/mul_b stay stable, so the multiplier output stays valid.
  - A consumer deasserting rsp_ready never loses or duplicates a result.
- Latency: accept at edge t, operands visible on mul_a/mul_b after t, response valid after edge t+1 (2-cycle latency).
  - Sustained throughput is one operation per cycle while rsp_ready=1.
- Simultaneous events:
  - Accept and response drain in the same cycle both occur; full pipelined flow.
  - Several req_valid at once: only the RR winner is granted; losers keep req_valid and operands stable until granted.
- Ordering: responses leave in accept order; rsp_id identifies the owner.
- Flags and results pass through unmodified. The block never alters NaN/Inf/zero encodings; the multiplier owns rounding and exception policy.
- No requester starves: any held request is granted within NUM_REQ accepts.

Test Plan:
- Single op: req 0 with a=0x40000000 (2.0), b=0x40400000 (3.0), rsp_ready=1 -> two edges after accept, rsp_valid=1, rsp_result=0x40C00000, rsp_id=0, rsp_flags=000, op_count=1.
- Round-robin: all four req_valid held from reset, rsp_ready=1 -> grants in order 0,1,2,3,0; rsp_id in the same sequence on consecutive cycles.
- Backpressure:
  - Stream ops from req 2, drop rsp_ready for 3 cycles -> rsp fields and mul_a/mul_b frozen, req_ready=0.
  - Restore rsp_ready -> every product is delivered exactly once, in order.
- Flags: a=0x7F800000 (exponent 255) from req 1 -> rsp_flags[2]=1, rsp_result=0x00000000. a=b=0x7F000000 -> rsp_flags[1]=1, rsp_result=0x7F800000.
- Wrap: preset by 65536 accepts -> op_count returns to 0x0000. With the pointer at 3 and requests on 0 and 3 -> 3 is granted, then 0.
- Async reset: assert rst_n low mid-stream between edges -> rsp_valid, req_ready and op_count go to 0 immediately without a clock edge. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Purpose: round-robin share of one external FP32 multiplier among NUM_REQ valid/ready requesters.
// Latency: 2 cycles from accept to response valid; one operation per cycle sustained.
// Backpressure: rsp_ready low freezes the response and operand registers and drops all req_ready.
module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [31:0]           mul_result,
    input  logic                  mul_exception,
    input  logic                  mul_overflow,
    input  logic                  mul_underflow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic [2:0]            rsp_flags,
    output logic [15:0]           op_count
);

    // Operand stage contents: owner plus the two operands driven to the multiplier.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     a;
        logic [31:0]     b;
    } op_t;

    // Response stage contents: owner, product and {exception, overflow, underflow}.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     result;
        logic [2:0]      flags;
    } rsp_t;

    op_t             op_q;
    logic            op_vld;
    rsp_t            rsp_q;
    logic            rsp_vld;
    logic [ID_W-1:0] rr_ptr;
    logic [15:0]     op_cnt;

    logic            rsp_adv;
    logic            op_adv;
    logic            arb_en;
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic            accept;
    logic [ID_W-1:0] ptr_nxt;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    int              cand_pos;
    logic [ID_W-1:0] cand;

    // A stage may advance when it is empty or the stage after it is moving.
    assign rsp_adv = !rsp_vld || rsp_ready;
    assign op_adv  = !op_vld || rsp_adv;

    // No handshake may complete while reset is held, even though the stages look empty.
    assign arb_en  = op_adv && rst_n;
    assign accept  = grant_vld && arb_en;

    // Round-robin search: first asserted request at or above the pointer, wrapping to 0.
    always_comb begin : rr_search
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_pos  = 0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_pos = int'(rr_ptr) + i;
            if (cand_pos >= NUM_REQ) begin
                cand_pos = cand_pos - NUM_REQ;
            end
            cand = ID_W'(cand_pos);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot ready toward the round-robin winner only when the operand stage can take it.
    always_comb begin : ready_decode
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Winner's operands and the pointer value that makes the next requester highest priority.
    assign sel_a   = req_a[32*int'(grant_idx) +: 32];
    assign sel_b   = req_b[32*int'(grant_idx) +: 32];
    assign ptr_nxt = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Operand register: loads on accept; an idle advance only clears valid so mul_a/mul_b hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vld <= 1'b0;
            op_q   <= '0;
        end else if (op_adv) begin
            if (accept) begin
                op_vld  <= 1'b1;
                op_q.id <= grant_idx;
                op_q.a  <= sel_a;
                op_q.b  <= sel_b;
            end else begin
                op_vld  <= 1'b0;
            end
        end
    end

    // Response register: captures the multiplier output for the operand stage's owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld <= 1'b0;
            rsp_q   <= '0;
        end else if (rsp_adv) begin
            if (op_vld) begin
                rsp_vld      <= 1'b1;
                rsp_q.id     <= op_q.id;
                rsp_q.result <= mul_result;
                rsp_q.flags  <= {mul_exception, mul_overflow, mul_underflow};
            end else begin
                rsp_vld      <= 1'b0;
            end
        end
    end

    // Pointer moves past the winner on each accept; the accept counter wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            op_cnt <= '0;
        end else if (accept) begin
            rr_ptr <= ptr_nxt;
            op_cnt <= op_cnt + 16'd1;
        end
    end

    assign mul_a      = op_q.a;
    assign mul_b      = op_q.b;
    assign rsp_valid  = rsp_vld;
    assign rsp_id     = rsp_q.id;
    assign rsp_result = rsp_q.result;
    assign rsp_flags  = rsp_q.flags;
    assign op_count   = op_cnt;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Purpose: directed self-checking bench for fp_mul_arbiter with a simple FP32 multiplier stand-in.
// Latency: expects responses two edges after accept.
// Backpressure: exercises rsp_ready stalls and checks frozen outputs and in-order delivery.
module tb_fp_mul_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic [31:0]  mul_a;
    logic [31:0]  mul_b;
    logic [31:0]  mul_result;
    logic         mul_exception;
    logic         mul_overflow;
    logic         mul_underflow;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    logic [2:0]   rsp_flags;
    logic [15:0]  op_count;

    int n_chk;
    int n_fail;

    fp_mul_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ready     (req_ready),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_result    (mul_result),
        .mul_exception (mul_exception),
        .mul_overflow  (mul_overflow),
        .mul_underflow (mul_underflow),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .op_count      (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: truncating FP32 multiply, normal numbers only, zero for exponent 0.
    logic [47:0] m_prod;
    logic [22:0] m_mant;
    int          m_exp;
    logic        m_sgn;
    always_comb begin
        mul_result    = '0;
        mul_exception = 1'b0;
        mul_overflow  = 1'b0;
        mul_underflow = 1'b0;
        m_prod        = '0;
        m_mant        = '0;
        m_exp         = 0;
        m_sgn         = mul_a[31] ^ mul_b[31];
        if (mul_a[30:23] == 8'hFF || mul_b[30:23] == 8'hFF) begin
            mul_exception = 1'b1;
        end else if (mul_a[30:23] != 8'h00 && mul_b[30:23] != 8'h00) begin
            m_prod = 48'({1'b1, mul_a[22:0]}) * 48'({1'b1, mul_b[22:0]});
            m_exp  = int'(mul_a[30:23]) + int'(mul_b[30:23]) - 127;
            if (m_prod[47]) begin
                m_exp  = m_exp + 1;
                m_mant = m_prod[46:24];
            end else begin
                m_mant = m_prod[45:23];
            end
            if (m_exp >= 255) begin
                mul_overflow = 1'b1;
                mul_result   = {m_sgn, 8'hFF, 23'h0};
            end else if (m_exp <= 0) begin
                mul_underflow = 1'b1;
                mul_result    = {m_sgn, 31'h0};
            end else begin
                mul_result = {m_sgn, m_exp[7:0], m_mant};
            end
        end
    end

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one request from a negedge until granted; returns at the negedge after the accept edge.
    task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b, output bit ok);
        bit fire;
        ok = 1'b0;
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        for (int k = 0; k < 20; k++) begin
            #1;
            fire = req_ready[r];
            @(negedge clk);
            if (fire) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = '0;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_chk++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        n_chk++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result got %h want 0", rsp_result); end
        n_chk++; if (rsp_flags !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_flags got %b want 000", rsp_flags); end
        n_chk++; if (mul_a !== 32'h0 || mul_b !== 32'h0) begin n_fail++; $display("FAIL reset_mul_ops got %h/%h want 0/0", mul_a, mul_b); end
        n_chk++; if (op_count !== 16'h0) begin n_fail++; $display("FAIL reset_op_count got %h want 0", op_count); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        bit ok;
        issue(0, 32'h40000000, 32'h40400000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL single_grant got none want grant to 0"); end
        #1;
        n_chk++; if (mul_a !== 32'h40000000 || mul_b !== 32'h40400000) begin n_fail++; $display("FAIL single_mul_ops got %h/%h want 40000000/40400000", mul_a, mul_b); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp got %b want 0", rsp_valid); end
        n_chk++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL single_op_count got %0d want 1", op_count); end
        @(negedge clk);
        #1;
        n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid); end
        n_chk++; if (rsp_result !== 32'h40C00000) begin n_fail++; $display("FAIL single_result got %h want 40c00000", rsp_result); end
        n_chk++; if (rsp_id !== 2'd0 || rsp_flags !== 3'b000) begin n_fail++; $display("FAIL single_id_flags got %0d/%b want 0/000", rsp_id, rsp_flags); end
        @(negedge clk);
    endtask

    task automatic test_flags();
        bit ok;
        issue(1, 32'h7F800000, 32'h3F800000, ok);
        @(negedge clk);
        #1;
        n_chk++; if (!ok || rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin n_fail++; $display("FAIL exc_handshake got ok=%b vld=%b id=%0d want 1/1/1", ok, rsp_valid, rsp_id); end
        n_chk++; if (rsp_flags !== 3'b100 || rsp_result !== 32'h0) begin n_fail++; $display("FAIL exc_flags got %b/%h want 100/00000000", rsp_flags, rsp_result); end
        @(negedge clk);
        issue(1, 32'h7F000000, 32'h7F000000, ok);
        @(negedge clk);
        #1;
        n_chk++; if (!ok || rsp_flags !== 3'b010 || rsp_result !== 32'h7F800000) begin n_fail++; $display("FAIL ovf_flags got ok=%b %b/%h want 010/7f800000", ok, rsp_flags, rsp_result); end
        @(negedge clk);
        issue(3, 32'h00800000, 32'h00800000, ok);
        @(negedge clk);
        #1;
        n_chk++; if (!ok || rsp_flags !== 3'b001 || rsp_result !== 32'h0 || rsp_id !== 2'd3) begin n_fail++; $display("FAIL unf_flags got ok=%b %b/%h id=%0d want 001/00000000 id 3", ok, rsp_flags, rsp_result, rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [31:0] av [4];
        logic [3:0]  exp_rdy;
        int          exp_id;
        av[0] = 32'h3F800000;
        av[1] = 32'h40000000;
        av[2] = 32'h40400000;
        av[3] = 32'h40800000;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = av[i];
            req_b[32*i +: 32] = 32'h3F800000;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            n_chk++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant cycle %0d got %b want %b", k, req_ready, exp_rdy); end
            if (k >= 2) begin
                exp_id = (k - 2) % 4;
                n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_result !== av[exp_id]) begin
                    n_fail++; $display("FAIL rr_rsp cycle %0d got vld=%b id=%0d res=%h want 1/%0d/%h", k, rsp_valid, rsp_id, rsp_result, exp_id, av[exp_id]);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] av [4];
        logic [31:0] ev [4];
        int sent;
        int got;
        bit fire_req;
        bit fire_rsp;
        av[0] = 32'h40000000; ev[0] = 32'h40800000;
        av[1] = 32'h40400000; ev[1] = 32'h40C00000;
        av[2] = 32'h40800000; ev[2] = 32'h41000000;
        av[3] = 32'h40A00000; ev[3] = 32'h41200000;
        sent = 0;
        got  = 0;
        req_b[95:64] = 32'h40000000;
        for (int c = 0; c < 40 && got < 4; c++) begin
            rsp_ready = !(c >= 2 && c <= 4);
            req_valid = '0;
            if (sent < 4) begin
                req_valid[2] = 1'b1;
                req_a[95:64] = av[sent];
            end
            #1;
            fire_req = req_valid[2] && req_ready[2];
            fire_rsp = rsp_valid && rsp_ready;
            if (c >= 2 && c <= 4) begin
                n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready cycle %0d got %b want 0000", c, req_ready); end
                n_chk++; if (rsp_valid !== 1'b1 || rsp_result !== ev[0] || rsp_id !== 2'd2) begin n_fail++; $display("FAIL bp_rsp_hold cycle %0d got %b/%h/%0d want 1/%h/2", c, rsp_valid, rsp_result, rsp_id, ev[0]); end
                n_chk++; if (mul_a !== av[1] || mul_b !== 32'h40000000) begin n_fail++; $display("FAIL bp_mul_hold cycle %0d got %h/%h want %h/40000000", c, mul_a, mul_b, av[1]); end
            end
            if (fire_rsp) begin
                n_chk++; if (rsp_id !== 2'd2 || rsp_result !== ev[got]) begin n_fail++; $display("FAIL bp_order item %0d got id=%0d res=%h want 2/%h", got, rsp_id, rsp_result, ev[got]); end
                got++;
            end
            @(negedge clk);
            if (fire_req) sent++;
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        n_chk++; if (got != 4 || sent != 4) begin n_fail++; $display("FAIL bp_count got %0d delivered %0d sent want 4/4", got, sent); end
        #1;
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got rsp_valid %b want 0", rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int cnt;
        bit ok;
        apply_reset();
        req_a[31:0] = 32'h3F800000;
        req_b[31:0] = 32'h3F800000;
        req_valid   = 4'b0001;
        cnt = 0;
        for (int k = 0; k < 70000 && cnt < 65535; k++) begin
            #1;
            if (req_ready[0]) cnt++;
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        n_chk++; if (cnt != 65535 || op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got %h after %0d accepts want ffff", op_count, cnt); end
        @(negedge clk);
        issue(0, 32'h3F800000, 32'h3F800000, ok);
        #1;
        n_chk++; if (!ok || op_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h want 0000", op_count); end
        @(negedge clk);
        issue(2, 32'h3F800000, 32'h3F800000, ok);
        req_a[127:96] = 32'h40000000;
        req_b[127:96] = 32'h3F800000;
        req_valid = 4'b1001;
        #1;
        n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ptr3 got %b want 1000", req_ready); end
        @(negedge clk);
        #1;
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ptr0 got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'h40000000;
            req_b[32*i +: 32] = 32'h40000000;
        end
        req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        n_chk++; if (op_count !== 16'd4 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got count=%0d vld=%b want 4/1", op_count, rsp_valid); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL arst_async got vld=%b rdy=%b want 0/0000", rsp_valid, req_ready); end
        n_chk++; if (op_count !== 16'd0 || mul_a !== 32'h0) begin n_fail++; $display("FAIL arst_regs got count=%0d mul_a=%h want 0/0", op_count, mul_a); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL arst_first_grant got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single_op();
        test_flags();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
